// File: rtl/demux_1x2_buffered.sv
// Registered 1-to-2 demultiplexer: each accepted word is steered by ctrl into one
// of two independent circular-buffer FIFOs, so a stalled consumer never blocks the other.

module demux_1x2_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop_req,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic             full,
    output logic [CW-1:0]    count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop      = pop_req && (count_q != '0);
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign valid   = (count_q != '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign rd_data = valid ? mem_q[rd_ptr_q] : '0;
endmodule

module demux_1x2_buffered #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         ctrl,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_0,
    output logic                         out_0_valid,
    input  logic                         out_0_ready,
    output logic [WIDTH-1:0]             out_1,
    output logic                         out_1_valid,
    input  logic                         out_1_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count_0,
    output logic [$clog2(DEPTH+1)-1:0]   count_1
);
    localparam int CW = $clog2(DEPTH + 1);

    logic full_0, full_1;
    logic push_0, push_1;

    // Readiness follows the selected FIFO only; a full FIFO refuses even with a pop pending.
    always_comb begin
        in_ready = !reset && !(ctrl ? full_1 : full_0);
        push_0   = in_valid && in_ready && !ctrl;
        push_1   = in_valid && in_ready && ctrl;
    end

    demux_1x2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo_0 (
        .clk     (clk),
        .reset   (reset),
        .push    (push_0),
        .wr_data (in_data),
        .pop_req (out_0_ready),
        .rd_data (out_0),
        .valid   (out_0_valid),
        .full    (full_0),
        .count   (count_0)
    );

    demux_1x2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo_1 (
        .clk     (clk),
        .reset   (reset),
        .push    (push_1),
        .wr_data (in_data),
        .pop_req (out_1_ready),
        .rd_data (out_1),
        .valid   (out_1_valid),
        .full    (full_1),
        .count   (count_1)
    );
endmodule

// File: tb/tb_demux_1x2_buffered.sv
// Bench for demux_1x2_buffered: directed steps plus random streaming, checked
// against per-output queue models of the two FIFOs.

module tb_demux_1x2_buffered;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             ctrl;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_0, out_1;
    logic             out_0_valid, out_1_valid;
    logic             out_0_ready, out_1_ready;
    logic [CW-1:0]    count_0, count_1;

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0] q0[$], q1[$];
    logic [WIDTH-1:0] got0[$], got1[$];
    logic [WIDTH-1:0] sent0[$], sent1[$];
    bit               last_acc;

    always #5 clk = ~clk;

    demux_1x2_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .ctrl        (ctrl),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_0       (out_0),
        .out_0_valid (out_0_valid),
        .out_0_ready (out_0_ready),
        .out_1       (out_1),
        .out_1_valid (out_1_valid),
        .out_1_ready (out_1_ready),
        .count_0     (count_0),
        .count_1     (count_1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("count_0", 32'(count_0), q0.size());
        chk("count_1", 32'(count_1), q1.size());
        chk("valid_0", 32'(out_0_valid), 32'(q0.size() != 0));
        chk("valid_1", 32'(out_1_valid), 32'(q1.size() != 0));
        chk("out_0", 32'(out_0), (q0.size() != 0) ? 32'(q0[0]) : 0);
        chk("out_1", 32'(out_1), (q1.size() != 0) ? 32'(q1[0]) : 0);
        chk("count_0_bound", 32'(32'(count_0) <= DEPTH), 1);
        chk("count_1_bound", 32'(32'(count_1) <= DEPTH), 1);
    endtask

    // One clock: check in_ready before the edge, advance the model, check state after.
    task automatic cycle();
        bit exp_rdy, push, p0, p1;
        @(negedge clk);
        exp_rdy = !reset && (ctrl ? (q1.size() != DEPTH) : (q0.size() != DEPTH));
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        push = in_valid && exp_rdy;
        p0   = !reset && (q0.size() != 0) && out_0_ready;
        p1   = !reset && (q1.size() != 0) && out_1_ready;
        if (!reset && out_0_valid && out_0_ready) got0.push_back(out_0);
        if (!reset && out_1_valid && out_1_ready) got1.push_back(out_1);
        @(posedge clk);
        #1;
        last_acc = 1'b0;
        if (reset) begin
            q0.delete();
            q1.delete();
        end else begin
            if (p0) void'(q0.pop_front());
            if (p1) void'(q1.pop_front());
            if (push) begin
                last_acc = 1'b1;
                if (ctrl) begin q1.push_back(in_data); sent1.push_back(in_data); end
                else      begin q0.push_back(in_data); sent0.push_back(in_data); end
            end
        end
        check_outputs();
    endtask

    task automatic clear_logs();
        got0.delete(); got1.delete(); sent0.delete(); sent1.delete();
    endtask

    initial begin
        int n_sent;
        reset = 1'b1; in_data = '0; ctrl = 1'b0; in_valid = 1'b0;
        out_0_ready = 1'b0; out_1_ready = 1'b0;
        @(posedge clk); #1;
        cycle();
        cycle();

        // Basic routing and one-cycle latency
        reset = 1'b0; out_0_ready = 1'b1; out_1_ready = 1'b1; in_valid = 1'b1;
        clear_logs();
        ctrl = 1'b0; in_data = 8'h00; cycle();
        chk("t1_latency_valid", 32'(out_0_valid), 1);
        ctrl = 1'b1; in_data = 8'hF0; cycle();
        chk("t1_out1_first", 32'(out_1), 32'h F0);
        ctrl = 1'b0; in_data = 8'hFF; cycle();
        in_valid = 1'b0;
        cycle(); cycle(); cycle();
        chk("t1_got0_size", got0.size(), 2);
        chk("t1_got1_size", got1.size(), 1);
        if (got0.size() == 2) begin
            chk("t1_got0_0", 32'(got0[0]), 32'h00);
            chk("t1_got0_1", 32'(got0[1]), 32'hFF);
        end
        if (got1.size() == 1) chk("t1_got1_0", 32'(got1[0]), 32'hF0);

        // Full FIFO 0 backpressure and order preservation
        clear_logs();
        out_0_ready = 1'b0; in_valid = 1'b1; ctrl = 1'b0;
        in_data = 8'h11; cycle();
        in_data = 8'h22; cycle();
        in_data = 8'h33; cycle();
        chk("t2_count_full", 32'(count_0), 2);
        chk("t2_ready_full", 32'(in_ready), 0);
        out_0_ready = 1'b1;
        cycle();
        chk("t2_refused_with_pop", 32'(last_acc), 0);
        cycle();
        chk("t2_accepted", 32'(last_acc), 1);
        in_valid = 1'b0;
        cycle(); cycle();
        chk("t2_got0_size", got0.size(), 3);
        if (got0.size() == 3) begin
            chk("t2_got0_0", 32'(got0[0]), 32'h11);
            chk("t2_got0_1", 32'(got0[1]), 32'h22);
            chk("t2_got0_2", 32'(got0[2]), 32'h33);
        end

        // FIFO 0 full and stalled does not block FIFO 1
        out_0_ready = 1'b0; out_1_ready = 1'b0; in_valid = 1'b1; ctrl = 1'b0;
        in_data = 8'h01; cycle();
        in_data = 8'h02; cycle();
        ctrl = 1'b1; in_data = 8'hAA;
        #1;
        chk("t3_ready_other", 32'(in_ready), 1);
        cycle();
        chk("t3_out1", 32'(out_1), 32'hAA);
        chk("t3_count0", 32'(count_0), 2);

        // Simultaneous push and pop on FIFO 1
        in_data = 8'h55; out_1_ready = 1'b1;
        cycle();
        chk("t4_count1", 32'(count_1), 1);
        chk("t4_out1", 32'(out_1), 32'h55);
        in_valid = 1'b0; out_0_ready = 1'b1;
        cycle(); cycle(); cycle();

        // Random streaming with alternating destination
        clear_logs();
        n_sent = 0;
        ctrl = 1'b0; in_data = WIDTH'($urandom);
        for (int i = 0; i < 400; i++) begin
            if (n_sent >= 10 && q0.size() == 0 && q1.size() == 0) break;
            in_valid    = (n_sent < 10);
            out_0_ready = 1'($urandom_range(0, 1));
            out_1_ready = 1'($urandom_range(0, 1));
            cycle();
            if (last_acc) begin
                n_sent++;
                ctrl    = ~ctrl;
                in_data = WIDTH'($urandom);
            end
        end
        in_valid = 1'b0; out_0_ready = 1'b1; out_1_ready = 1'b1;
        chk("t5_all_sent", n_sent, 10);
        chk("t5_drained", 32'(q0.size() + q1.size()), 0);
        chk("t5_size0", got0.size(), sent0.size());
        chk("t5_size1", got1.size(), sent1.size());
        for (int i = 0; i < sent0.size() && i < got0.size(); i++)
            chk("t5_seq0", 32'(got0[i]), 32'(sent0[i]));
        for (int i = 0; i < sent1.size() && i < got1.size(); i++)
            chk("t5_seq1", 32'(got1[i]), 32'(sent1[i]));

        // Mid-stream reset flushes both FIFOs
        out_0_ready = 1'b0; out_1_ready = 1'b0; in_valid = 1'b1;
        ctrl = 1'b0; in_data = 8'hA1; cycle();
        in_data = 8'hA2; cycle();
        ctrl = 1'b1; in_data = 8'hB1; cycle();
        chk("t6_pre_count0", 32'(count_0), 2);
        chk("t6_pre_count1", 32'(count_1), 1);
        reset = 1'b1;
        #1;
        chk("t6_ready_in_reset", 32'(in_ready), 0);
        cycle();
        chk("t6_count0", 32'(count_0), 0);
        chk("t6_count1", 32'(count_1), 0);
        chk("t6_out0", 32'(out_0), 0);
        chk("t6_out1", 32'(out_1), 0);
        reset = 1'b0;
        #1;
        chk("t6_ready_after", 32'(in_ready), 1);
        in_valid = 1'b0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/demux_1x2_buffered.md
Name: demux_1x2_buffered

Overview:
- Registered 1-to-2 demultiplexer: the routing counterpart of mux_2x1.
- Accepts a single valid/ready input stream and steers each accepted word to output 0 or output 1, as selected by ctrl sampled with that word.
- Each output has its own FIFO, so one stalled consumer does not block words routed to the other output.
- Sits between a single producer and two downstream consumers in the datapath.

Parameters:
WIDTH, 8, data width of in_data, out_0 and out_1
DEPTH, 2, entries per output FIFO; any integer >= 2

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
in_data  input  WIDTH  input word
ctrl  input  1  destination select for in_data: 0 -> out_0, 1 -> out_1
in_valid  input  1  in_data/ctrl valid
in_ready  output  1  block can accept the word currently presented
out_0  output  WIDTH  head word of FIFO 0
out_0_valid  output  1  FIFO 0 non-empty
out_0_ready  input  1  consumer 0 accepts out_0
out_1  output  WIDTH  head word of FIFO 1
out_1_valid  output  1  FIFO 1 non-empty
out_1_ready  input  1  consumer 1 accepts out_1
count_0  output  $clog2(DEPTH+1)  FIFO 0 occupancy
count_1  output  $clog2(DEPTH+1)  FIFO 1 occupancy

Behaviour:
- Reset (synchronous, active-high), applied at any rising edge with reset=1:
  - count_0=0, count_1=0, out_0_valid=0, out_1_valid=0, out_0=0, out_1=0.
  - Both FIFOs flushed, including mid-stream.
- in_ready:
  - Combinational: in_ready = !reset && (ctrl ? count_1!=DEPTH : count_0!=DEPTH).
  - Depends on ctrl, so it may toggle as the producer changes ctrl.
- Push: at a rising edge with in_valid && in_ready, in_data is written to the tail of FIFO[ctrl].
  - in_valid=0 or in_ready=0: nothing is written; producer holds the word.
- Pop: at a rising edge with out_k_valid && out_k_ready, the head of FIFO k is removed.
  - out_k_ready while out_k_valid=0 has no effect.
- Outputs:
  - out_k_valid = (count_k != 0), registered state.
  - out_k = head entry when count_k!=0, else 0.
- Latency: a word pushed at edge N into an empty FIFO k appears on out_k with out_k_valid=1 immediately after edge N (one cycle). There is no combinational in-to-out path.
- Ordering: strict FIFO order per output. There is no ordering relation between the two outputs.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle: count unchanged, both operations take effect.
  - Allowed only when not full, since in_ready=0 when full. A full FIFO with a pop present still refuses the push that cycle (no same-cycle pass-through).
  - Push to one FIFO and pop from the other in the same cycle are independent.
- Full/empty: count_k saturates at DEPTH via in_ready gating and never underflows via valid gating.
- Storage: circular buffer per FIFO; read/write pointers wrap modulo DEPTH. DEPTH need not be a power of two.
- Assertion (bench): count_k never exceeds DEPTH, and data is never written to a full FIFO.

Test Plan:
1. Reset, then ctrl=0, in_data=0x00; ctrl=1, in_data=0xF0; ctrl=0, in_data=0xFF, in_valid=1 each cycle, both readies=1 -> out_0 delivers 0x00, 0xFF; out_1 delivers 0xF0; each word appears one cycle after acceptance.
2. out_0_ready=0, DEPTH=2; push 0x11, 0x22, 0x33 with ctrl=0 -> count_0=2, in_ready=0 while 0x33 is presented. Raise out_0_ready -> 0x11 pops, 0x33 is accepted next cycle, order 0x11, 0x22, 0x33 preserved.
3. FIFO 0 full and stalled; present ctrl=1, in_data=0xAA -> in_ready=1, 0xAA is accepted, out_1=0xAA next cycle, count_0 stays 2.
4. count_1=1; in the same cycle push 0x55 (ctrl=1) and pop with out_1_ready=1 -> count_1 remains 1, out_1=0x55 afterwards.
5. Stream 10 words alternating ctrl with randomly toggling readies -> each output sequence matches the reference model. Pointer wrap is exercised, and no loss or duplication occurs.
6. With count_0=2 and count_1=1, assert reset for one cycle mid-stream -> next cycle counts=0, valids=0, out_0=out_1=0; in_ready=0 while reset=1 and 1 after it deasserts.
